mux_scan_serializer: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 29 ++
 rtl/mux8x1.sv | 11 +
 rtl/mux_scan_serializer_counter.sv | 41 ++++
 rtl/mux_scan_serializer.sv | 106 ++++++++++
 tb/tb_mux_scan_serializer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan serializer.
// Holds default widths, the serializer state encoding and helpers that
// derive the first/last select position from the scan direction.
package mux_scan_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int SEL_W_DEF     = 3;
    localparam bit MSB_FIRST_DEF = 1'b0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Select value of the first bit of a frame.
    function automatic int sel_first(input bit msb_first, input int width);
        return msb_first ? (width - 1) : 0;
    endfunction

    // Select value of the final bit of a frame.
    function automatic int sel_last(input bit msb_first, input int width);
        return msb_first ? 0 : (width - 1);
    endfunction

    // Default-configuration positions (LSB first).
    localparam int SEL_FIRST = sel_first(MSB_FIRST_DEF, WIDTH_DEF);
    localparam int SEL_LAST  = sel_last(MSB_FIRST_DEF, WIDTH_DEF);

endpackage

// File: rtl/mux8x1.sv
// Combinational 8:1 multiplexer: y = i[s].
// Ports: i data inputs, s select, y selected bit.
module mux8x1 (
    input  logic [7:0] i,
    input  logic [2:0] s,
    output logic       y
);

    assign y = i[s];

endmodule

// File: rtl/mux_scan_serializer_counter.sv
// Up/down select counter with synchronous load, enable and terminal count.
// Ports: clk/rst, load + load_val (priority over en), en steps by one in the
// DOWN direction, cnt is the registered select, tc flags cnt == LAST.
module scan_index_counter #(
    parameter int          SEL_W = 3,
    parameter bit          DOWN  = 1'b0,
    parameter logic [SEL_W-1:0] LAST = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    input  logic             en,
    output logic [SEL_W-1:0] cnt,
    output logic             tc
);

    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = DOWN ? (cnt_q - SEL_W'(1)) : (cnt_q + SEL_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/mux_scan_serializer.sv
// Loads a word, holds it on the mux inputs and scans the mux select so the
// mux output streams out one bit per accepted serial handshake.
// Ports: load_* word handshake (ready only in IDLE), mux_i/mux_s drive the
// mux, mux_y returns from it, ser_* serial stream with last flag, done pulse.
module mux_scan_serializer
    import mux_scan_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int SEL_W     = SEL_W_DEF,
    parameter bit MSB_FIRST = MSB_FIRST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] mux_i,
    output logic [SEL_W-1:0] mux_s,
    input  logic             mux_y,
    output logic             ser_bit,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             done
);

    localparam logic [SEL_W-1:0] SEL_FIRST_P = SEL_W'(sel_first(MSB_FIRST, WIDTH));
    localparam logic [SEL_W-1:0] SEL_LAST_P  = SEL_W'(sel_last(MSB_FIRST, WIDTH));

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mux_i_q, mux_i_d;
    logic             done_q, done_d;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_tc;
    logic             load_fire;
    logic             ser_fire;

    // Handshake qualifiers decode from registered state only.
    assign load_ready = (state_q == IDLE);
    assign ser_valid  = (state_q == SEND);
    assign ser_last   = ser_valid && cnt_tc;
    assign ser_bit    = mux_y;
    assign load_fire  = load_valid && load_ready;
    assign ser_fire   = ser_valid && ser_ready;

    always_comb begin
        state_d  = state_q;
        mux_i_d  = mux_i_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_fire) begin
                    mux_i_d  = load_data;
                    cnt_load = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                // Last-bit check comes before the step, so the select
                // never wraps past the end of the frame.
                if (ser_fire) begin
                    if (cnt_tc) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mux_i_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mux_i_q <= mux_i_d;
            done_q  <= done_d;
        end
    end

    scan_index_counter #(
        .SEL_W (SEL_W),
        .DOWN  (MSB_FIRST),
        .LAST  (SEL_LAST_P)
    ) u_idx (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (SEL_FIRST_P),
        .en       (cnt_en),
        .cnt      (mux_s),
        .tc       (cnt_tc)
    );

    assign mux_i = mux_i_q;
    assign done  = done_q;

endmodule

// File: tb/tb_mux_scan_serializer.sv
module tb_mux_scan_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // LSB-first instance
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_data  = 8'h00;
    logic [7:0] mux_i;
    logic [2:0] mux_s;
    logic       mux_y;
    logic       ser_bit, ser_valid, ser_last, done;
    logic       ser_ready  = 1'b1;

    // MSB-first instance
    logic       load_valid_m = 1'b0;
    logic       load_ready_m;
    logic [7:0] load_data_m  = 8'h00;
    logic [7:0] mux_i_m;
    logic [2:0] mux_s_m;
    logic       mux_y_m;
    logic       ser_bit_m, ser_valid_m, ser_last_m, done_m;
    logic       ser_ready_m  = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_scan_serializer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b0)) u_dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .mux_i(mux_i), .mux_s(mux_s), .mux_y(mux_y),
        .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_ready(ser_ready),
        .ser_last(ser_last), .done(done)
    );
    mux8x1 u_mux (.i(mux_i), .s(mux_s), .y(mux_y));

    mux_scan_serializer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b1)) u_dut_m (
        .clk(clk), .rst(rst), .load_valid(load_valid_m), .load_ready(load_ready_m),
        .load_data(load_data_m), .mux_i(mux_i_m), .mux_s(mux_s_m), .mux_y(mux_y_m),
        .ser_bit(ser_bit_m), .ser_valid(ser_valid_m), .ser_ready(ser_ready_m),
        .ser_last(ser_last_m), .done(done_m)
    );
    mux8x1 u_mux_m (.i(mux_i_m), .s(mux_s_m), .y(mux_y_m));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a word into the LSB-first instance and check the whole frame.
    task automatic frame_lsb(input logic [7:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("f_valid", ser_valid, 1);
            check("f_sel", mux_s, k);
            check("f_bit", ser_bit, d[k]);
            check("f_last", ser_last, (k == 7));
            check("f_ldrdy", load_ready, 0);
            check("f_done", done, 0);
            tick();
        end
        check("f_done_pulse", done, 1);
        check("f_idle_valid", ser_valid, 0);
        check("f_idle_ldrdy", load_ready, 1);
        tick();
        check("f_done_clear", done, 0);
    endtask

    initial begin
        logic [7:0]  d3;
        logic [15:0] bits;
        int          nbits, ndone, first_done, second_done;

        // Reset state
        #12;
        check("rst_ldrdy", load_ready, 1);
        check("rst_valid", ser_valid, 0);
        check("rst_last", ser_last, 0);
        check("rst_done", done, 0);
        check("rst_mux_i", mux_i, 0);
        check("rst_mux_s", mux_s, 0);
        check("rst_mux_s_m", mux_s_m, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 1: LSB first, 8'hA5
        frame_lsb(8'hA5);

        // 2: MSB first, 8'h80 -> select 7..0, bits 1 then zeros
        load_valid_m = 1'b1;
        load_data_m  = 8'h80;
        tick();
        load_valid_m = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("m_valid", ser_valid_m, 1);
            check("m_sel", mux_s_m, 7 - k);
            check("m_bit", ser_bit_m, (k == 0));
            check("m_last", ser_last_m, (k == 7));
            tick();
        end
        check("m_done", done_m, 1);
        tick();
        check("m_done_clear", done_m, 0);

        // 3: 8'h3C with a 3-cycle stall at select 3
        d3 = 8'h3C;
        load_valid = 1'b1;
        load_data  = d3;
        tick();
        load_valid = 1'b0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            check("bp_sel", mux_s, k);
            check("bp_bit", ser_bit, d3[k]);
            if (k == 3) begin
                ser_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check("bp_hold_sel", mux_s, 3);
                    check("bp_hold_valid", ser_valid, 1);
                    check("bp_hold_bit", ser_bit, 1);
                    check("bp_hold_last", ser_last, 0);
                    if (done) ndone++;
                end
                ser_ready = 1'b1;
            end
            tick();
            if (done) ndone++;
        end
        tick();
        if (done) ndone++;
        check("bp_done_count", ndone, 1);

        // 4: load attempt during SEND is ignored
        load_valid = 1'b1;
        load_data  = 8'h00;
        tick();
        load_data  = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            check("ign_bit", ser_bit, 0);
            check("ign_mux_i", mux_i, 8'h00);
            check("ign_ldrdy", load_ready, 0);
            if (k == 7) load_valid = 1'b0;
            tick();
        end
        check("ign_done", done, 1);
        check("ign_ldrdy_back", load_ready, 1);
        tick();
        check("ign_no_capture", ser_valid, 0);

        // 5: asynchronous reset mid-frame at select 4
        load_valid = 1'b1;
        load_data  = 8'hC3;
        tick();
        load_valid = 1'b0;
        repeat (4) tick();
        check("ar_pre_sel", mux_s, 4);
        #2 rst = 1'b1;
        #1;
        check("ar_mux_i", mux_i, 0);
        check("ar_mux_s", mux_s, 0);
        check("ar_valid", ser_valid, 0);
        check("ar_last", ser_last, 0);
        check("ar_done", done, 0);
        check("ar_ldrdy", load_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("ar_no_done", done, 0);
        frame_lsb(8'h01);

        // 6: back-to-back frames with load_valid held
        load_valid = 1'b1;
        load_data  = 8'hF0;
        tick();
        load_data  = 8'h0F;
        bits = '0; nbits = 0; ndone = 0; first_done = 0; second_done = 0;
        for (int c = 1; c <= 18; c++) begin
            if (ser_valid && nbits < 16) begin
                bits[nbits] = ser_bit;
                nbits++;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) first_done = c;
                else second_done = c;
            end
            if (c == 18) load_valid = 1'b0;
            else tick();
        end
        check("b2b_bits", bits, 16'h0FF0);
        check("b2b_nbits", nbits, 16);
        check("b2b_ndone", ndone, 2);
        check("b2b_first_done", first_done, 9);
        check("b2b_second_done", second_done, 18);
        tick();
        check("b2b_idle_valid", ser_valid, 0);
        check("b2b_idle_ldrdy", load_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
